// File: rtl/var_lat_pkg.sv
// Shared types and default configuration for the variable-latency unit
// issue controller and its result FIFO.
package var_lat_pkg;

   // Controller FSM states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      ERR  = 2'd2
   } state_e;

   // Longest latency the attached unit can legally take (in[1:0] = 3).
   localparam int unsigned MAX_UNIT_LAT = 4;

   // Default configuration.
   localparam int unsigned DEF_WIDTH   = 32;
   localparam int unsigned DEF_DEPTH   = 2;
   localparam int unsigned DEF_TIMEOUT = 7;

endpackage

// File: rtl/var_lat_result_fifo.sv
// Small synchronous result FIFO. Registered head (no fall-through), pointers
// wrap modulo DEPTH so any entry count works. Push is guarded against a full
// FIFO, although the controller reserves space before issuing.
module var_lat_result_fifo
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [CNT_W-1:0] count_o,
   output logic             head_valid_o,
   output logic [WIDTH-1:0] head_data_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_eff_s;
   logic             pop_eff_s;

   // Advance a pointer with wrap at DEPTH-1.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) begin
         return {PTR_W{1'b0}};
      end else begin
         return p + PTR_W'(1);
      end
   endfunction

   assign pop_eff_s  = pop_i && (count_q != {CNT_W{1'b0}});
   assign push_eff_s = push_i && ((count_q != CNT_W'(DEPTH)) || pop_eff_s);

   // Next pointer and occupancy values from the effective push/pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_eff_s) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_eff_s) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_eff_s, pop_eff_s})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers; reset flushes the FIFO.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         count_q  <= {CNT_W{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents need no reset because count gates validity.
   always_ff @(posedge clock) begin
      if (push_eff_s) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   assign count_o      = count_q;
   assign head_valid_o = (count_q != {CNT_W{1'b0}});
   assign head_data_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/var_lat_issue_ctrl.sv
// Issue controller for a start/in/done/out unit whose latency (1-4 cycles)
// depends on in[1:0]. Accepts requests on a valid/ready port, keeps at most
// one operation in flight, captures the result in the done cycle into a
// small in-order FIFO, and flags a unit that never finishes.
module var_lat_issue_ctrl
   import var_lat_pkg::*;
#(
   parameter int unsigned WIDTH   = DEF_WIDTH,
   parameter int unsigned DEPTH   = DEF_DEPTH,
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_data,
   output logic             core_start,
   output logic [WIDTH-1:0] core_in,
   input  logic             core_done,
   input  logic [WIDTH-1:0] core_out,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             busy,
   output logic             timeout_err
);

   // A watchdog shorter than the slowest legal unit would trip on healthy
   // operations, so the limit is never allowed below MAX_UNIT_LAT+1.
   localparam int unsigned TO_EFF = (TIMEOUT > MAX_UNIT_LAT) ? TIMEOUT : (MAX_UNIT_LAT + 1);
   localparam int unsigned TMR_W  = $clog2(TO_EFF + 1);
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

   state_e           state_q, state_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic             busy_q;
   logic             err_q;
   logic [CNT_W-1:0] count_s;
   logic             req_ready_s;
   logic             accept_s;
   logic             push_s;
   logic             pop_s;
   logic             room_idle_s;
   logic             room_b2b_s;

   assign pop_s  = rsp_valid && rsp_ready;
   assign push_s = (state_q == BUSY) && core_done;

   // Space checks: from IDLE one free slot is enough; issuing in the done
   // cycle needs a slot beyond the result being pushed right now.
   always_comb begin
      room_idle_s = (count_s < CNT_W'(DEPTH));
      room_b2b_s  = ((count_s - CNT_W'(pop_s)) < CNT_W'(DEPTH - 1));
   end

   // Request acceptance: only when the unit is idle or finishing this cycle.
   always_comb begin
      req_ready_s = 1'b0;
      if (reset) begin
         req_ready_s = 1'b0;
      end else begin
         case (state_q)
            IDLE:    req_ready_s = room_idle_s;
            BUSY:    req_ready_s = core_done && room_b2b_s;
            ERR:     req_ready_s = 1'b0;
            default: req_ready_s = 1'b0;
         endcase
      end
   end

   assign accept_s   = req_valid && req_ready_s;
   assign req_ready  = req_ready_s;
   assign core_start = accept_s;
   assign core_in    = req_data;

   // Next state and watchdog timer.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               state_d = BUSY;
               timer_d = {TMR_W{1'b0}};
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            if (timer_q != TMR_W'(TO_EFF)) begin
               timer_d = timer_q + TMR_W'(1);
            end else begin
               timer_d = timer_q;
            end
            if (core_done) begin
               if (accept_s) begin
                  state_d = BUSY;
                  timer_d = {TMR_W{1'b0}};
               end else begin
                  state_d = IDLE;
               end
            end else if (timer_q == TMR_W'(TO_EFF - 1)) begin
               state_d = ERR;
            end else begin
               state_d = BUSY;
            end
         end
         ERR: begin
            state_d = ERR;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, timer and registered status outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         timer_q <= {TMR_W{1'b0}};
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         busy_q  <= (state_d == BUSY);
         err_q   <= (state_d == ERR);
      end
   end

   assign busy        = busy_q;
   assign timeout_err = err_q;

   var_lat_result_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clock        (clock),
      .reset        (reset),
      .push_i       (push_s),
      .push_data_i  (core_out),
      .pop_i        (pop_s),
      .count_o      (count_s),
      .head_valid_o (rsp_valid),
      .head_data_o  (rsp_data)
   );

endmodule

// File: tb/tb_var_lat_issue_ctrl.sv
// Bench for var_lat_issue_ctrl: a behavioural unit model plus a queue-based
// reference of outstanding operations, driven by directed scenarios and
// randomized traffic.
module tb_var_lat_issue_ctrl;

   localparam int W       = 32;
   localparam int DEPTH   = 2;
   localparam int TIMEOUT = 7;
   localparam int NEVER   = 1 << 30;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic [W-1:0] req_data = '0;
   logic         core_start;
   logic [W-1:0] core_in;
   logic         core_done = 1'b0;
   logic [W-1:0] core_out = '0;
   logic         rsp_valid;
   logic         rsp_ready = 1'b0;
   logic [W-1:0] rsp_data;
   logic         busy;
   logic         timeout_err;

   var_lat_issue_ctrl #(
      .WIDTH   (W),
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_data    (req_data),
      .core_start  (core_start),
      .core_in     (core_in),
      .core_done   (core_done),
      .core_out    (core_out),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_data    (rsp_data),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   always #5 clock = ~clock;

   // Outstanding operations in issue order; rdy is the first cycle the
   // result may appear at the response port (NEVER while still in flight).
   typedef struct {
      logic [W-1:0] val;
      int           rdy;
   } item_t;
   item_t q[$];

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;

   // Controller-level reference state.
   bit ctl_busy = 1'b0;
   bit err      = 1'b0;
   int busy_cycles = 0;

   // Unit model.
   bit           unit_busy = 1'b0;
   int           unit_rem  = 0;
   logic [W-1:0] unit_in   = '0;
   bit           stall      = 1'b0;
   bit           force_done = 1'b0;
   logic [W-1:0] xmask      = '0;

   bit           last_acc = 1'b0;
   logic [W-1:0] lst[$];
   int           idx = 0;
   bit           rv_r = 1'b0;
   logic [W-1:0] rd_r = '0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One clock cycle: drive after the rising edge, check at the falling edge,
   // then advance the reference to the state after the next rising edge.
   task automatic step(input bit rv, input logic [W-1:0] rd, input bit rr, input bit rst);
      bit udone, done_now, pop_now, rsp_v_exp, rdy_exp, start_exp, timeout_now;
      int bc;
      @(posedge clock);
      #1;
      cyc++;
      udone     = unit_busy && (unit_rem == 0) && !stall;
      reset     = rst;
      req_valid = rv;
      req_data  = rd;
      rsp_ready = rr;
      core_done = udone || force_done;
      core_out  = udone ? (unit_in ^ xmask) : W'($urandom);
      @(negedge clock);

      done_now  = core_done && ctl_busy;
      rsp_v_exp = (q.size() > 0) && (q[0].rdy <= cyc);
      pop_now   = rsp_v_exp && rr;
      bc        = busy_cycles + 1;
      if (rst || err) begin
         rdy_exp = 1'b0;
      end else if (!ctl_busy) begin
         rdy_exp = (q.size() < DEPTH);
      end else if (done_now) begin
         rdy_exp = ((q.size() - int'(pop_now)) < DEPTH);
      end else begin
         rdy_exp = 1'b0;
      end
      start_exp = rv && rdy_exp;

      chk("req_ready", 64'(req_ready), 64'(rdy_exp));
      chk("core_start", 64'(core_start), 64'(start_exp));
      chk("core_in", 64'(core_in), 64'(rd));
      if (!rst) begin
         chk("rsp_valid", 64'(rsp_valid), 64'(rsp_v_exp));
         chk("busy", 64'(busy), 64'(ctl_busy));
         chk("timeout_err", 64'(timeout_err), 64'(err));
         if (rsp_v_exp) begin
            chk("rsp_data", 64'(rsp_data), 64'(q[0].val));
         end
      end
      last_acc = rv && req_ready;

      if (rst) begin
         q.delete();
         ctl_busy    = 1'b0;
         err         = 1'b0;
         busy_cycles = 0;
         unit_busy   = 1'b0;
         unit_rem    = 0;
      end else begin
         timeout_now = ctl_busy && !done_now && (bc == TIMEOUT);
         if (pop_now) void'(q.pop_front());
         if (ctl_busy) busy_cycles = bc;
         if (done_now) q[q.size()-1].rdy = cyc + 1;
         if (start_exp) begin
            q.push_back('{rd ^ xmask, NEVER});
            ctl_busy    = 1'b1;
            busy_cycles = 0;
         end else if (done_now) begin
            ctl_busy = 1'b0;
         end else if (timeout_now) begin
            err      = 1'b1;
            ctl_busy = 1'b0;
            void'(q.pop_back());
         end
         if (udone) begin
            unit_busy = 1'b0;
         end else if (unit_busy && unit_rem > 0) begin
            unit_rem--;
         end
         if (core_start) begin
            unit_busy = 1'b1;
            unit_rem  = int'(core_in[1:0]);
            unit_in   = core_in;
         end
      end
   endtask

   // Present lst[idx..] as held requests for ncyc cycles.
   task automatic run_list(input bit rr, input int ncyc);
      for (int i = 0; i < ncyc; i++) begin
         if (idx < lst.size()) begin
            step(1'b1, lst[idx], rr, 1'b0);
         end else begin
            step(1'b0, 32'h0000_0000, rr, 1'b0);
         end
         if (last_acc) idx++;
      end
   endtask

   initial begin
      step(1'b0, 32'h0, 1'b0, 1'b1);
      step(1'b0, 32'h0, 1'b0, 1'b1);

      // Single operation, d=1.
      lst = '{32'h0000_0005};
      idx = 0;
      run_list(1'b1, 8);
      chk("single_issued", 64'(idx), 64'd1);

      // Latency sweep d=0..3.
      lst = '{32'h10, 32'h11, 32'h12, 32'h13};
      idx = 0;
      run_list(1'b1, 24);
      chk("sweep_issued", 64'(idx), 64'd4);

      // Back-pressure: third request must wait for the consumer.
      lst = '{32'hA0, 32'hA1, 32'hA2};
      idx = 0;
      run_list(1'b0, 12);
      chk("bp_third_held", 64'(idx), 64'd2);
      run_list(1'b1, 12);
      chk("bp_third_issued", 64'(idx), 64'd3);

      // Back-to-back issue with an empty FIFO.
      lst = '{32'h20, 32'h21, 32'h22, 32'h23};
      idx = 0;
      run_list(1'b1, 20);
      chk("b2b_issued", 64'(idx), 64'd4);

      // Reset in the middle of a d=3 operation.
      lst = '{32'h33};
      idx = 0;
      run_list(1'b1, 1);
      chk("rstmid_issued", 64'(idx), 64'd1);
      step(1'b0, 32'h0, 1'b1, 1'b1);
      for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

      // Watchdog: unit never completes.
      stall = 1'b1;
      lst = '{32'h40};
      idx = 0;
      run_list(1'b1, 10);
      chk("wd_err_set", 64'(timeout_err), 64'd1);
      step(1'b1, 32'h44, 1'b1, 1'b0);
      force_done = 1'b1;
      step(1'b0, 32'h0, 1'b1, 1'b0);
      force_done = 1'b0;
      for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
      stall = 1'b0;
      step(1'b0, 32'h0, 1'b1, 1'b1);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("wd_err_cleared", 64'(timeout_err), 64'd0);

      // Randomized traffic with a non-trivial unit function.
      xmask = 32'hDEAD_BEEF;
      rv_r  = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         bit rst_now;
         if (!rv_r || last_acc) begin
            rv_r = ($urandom_range(0, 9) < 7);
            rd_r = W'($urandom);
         end
         rst_now = ($urandom_range(0, 199) == 0);
         step(rv_r, rd_r, ($urandom_range(0, 9) < 6), rst_now);
         if (rst_now) rv_r = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/var_lat_issue_ctrl.md
Name: var_lat_issue_ctrl

Overview:
Controller for the data-dependent-latency unit (start/in/done/out, no busy or ready output, 1-4 cycle latency chosen by in[1:0]).
- Upstream side: a valid/ready request port. Issues exactly one start pulse per accepted request and never restarts the unit while an operation is in flight.
- Downstream side: captures out in the single cycle done is high and presents results in order on a valid/ready response port, through a small result FIFO.
- Includes a watchdog that flags a unit that never asserts done.

Parameters:
DEPTH, 2, result FIFO entries (>=1; power of two not required)
TIMEOUT, 7, BUSY cycles without done before error (must exceed max unit latency of 4)
WIDTH, 32, data width

Ports:
clock  in  1  clock
reset  in  1  reset, synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  request accepted this cycle when both high
req_data  in  WIDTH  request operand; bits [1:0] set unit latency
core_start  out  1  start pulse to unit
core_in  out  WIDTH  operand to unit (= req_data, combinational)
core_done  in  1  unit done (single-cycle)
core_out  in  WIDTH  unit result, valid only while core_done
rsp_valid  out  1  FIFO head valid
rsp_ready  in  1  consumer accepts head
rsp_data  out  WIDTH  FIFO head data
busy  out  1  operation in flight (state == BUSY)
timeout_err  out  1  sticky watchdog error

Behaviour:
- Reset: state IDLE, FIFO empty, timer 0. Outputs: req_ready 0 during reset, rsp_valid 0, busy 0, timeout_err 0, core_start 0. Unit shares the same reset.
- FSM states:
  - IDLE: req_ready = (count < DEPTH). On accept: core_start=1, core_in=req_data, timer<=0, go to BUSY.
  - BUSY: timer += 1 each cycle.
    - core_done: push core_out.
    - Back-to-back: req_ready = core_done && (count - pop < DEPTH-1). If a request is accepted, core_start=1 in the same cycle, stay BUSY, timer<=0. Otherwise go to IDLE.
    - No done and timer == TIMEOUT-1: go to ERR.
  - ERR: req_ready 0, core_start 0, timeout_err 1. FIFO still drains. Leaves ERR only on reset.
- core_start is combinational from the accept and asserted only when the unit is idle or finishing this cycle.
- core_done outside BUSY is ignored: no push, and timeout_err is not set.
- Latency: accept at cycle t with d=req_data[1:0] gives core_done at t+1+d, and rsp_data/rsp_valid at t+2+d (FIFO registered; no fall-through).
- FIFO:
  - Space is reserved at issue, so a push never meets a full FIFO.
  - Simultaneous push and pop at any count: count unchanged, order kept.
  - Pop when rsp_valid && rsp_ready. rsp_data is stable while rsp_valid && !rsp_ready.
  - Pointers wrap modulo DEPTH.
- Ordering: strictly in order; one operation in flight at most.
- Reset mid-BUSY: the in-flight result is discarded, FIFO is flushed, and state returns to IDLE the next cycle.
- Widths: timer is clog2(TIMEOUT+1) bits and saturates; count is clog2(DEPTH+1) bits.

Decomposition:
- Package var_lat_pkg holds:
  - state enum {IDLE, BUSY, ERR}
  - MAX_UNIT_LAT=4
  - default WIDTH/DEPTH/TIMEOUT constants
- Sub-module var_lat_result_fifo: synchronous FIFO (push/pop/count/head). The FSM and watchdog stay in the top module.

Test Plan:
- Single op: req_data=0x00000005 accepted at t, core_done at t+2 -> rsp_valid at t+3, rsp_data=0x00000005, busy high t+1..t+2, one core_start pulse.
- Latency sweep: req_data=0x10,0x11,0x12,0x13 (d=0..3), rsp_ready=1 -> results in order at t+2,t+3,t+4,t+5 after each accept; no start while busy.
- Back-pressure: rsp_ready=0, DEPTH=2, send 3 requests (0xA0,0xA1,0xA2):
  - req_ready drops after the second result is pushed, and no third start occurs.
  - Raise rsp_ready -> 0xA0, 0xA1 pop, then third issued.
- Back-to-back: FIFO empty and req_valid held -> new core_start in the same cycle core_done=1, stays BUSY, no idle gap.
- Watchdog: stub unit holding core_done=0, TIMEOUT=7 -> timeout_err=1 at the 7th BUSY cycle, req_ready=0 thereafter. A later core_done pushes nothing; cleared by reset.
- Reset mid-op: reset at t+1 of a d=3 op -> rsp_valid never asserts for it, FIFO empty, IDLE with req_ready=1 after reset deasserts.
